nonce_dispatch_ctrl: RTL and testbench

Scheduler between the block store and a bank of parallel hash cores inside `bcminer`. On each new block it partitions the nonce space into fixed-size chunks and hands one chunk to each idle core. It round-robin arbitrates the cores' winning-nonce results into the nonce buffer writer. It also handles exhaustion of the nonce space and abort when a new block supersedes the current one.

---
 rtl/nonce_dispatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_nonce_dispatch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl: hands out fixed-size nonce chunks to idle hash cores and
// round-robin merges the cores' winning nonces into the nonce buffer writer.
module nonce_dispatch_ctrl #(
    parameter int unsigned NCORES    = 4,
    parameter int unsigned COUNTBITS = 8,
    parameter int unsigned NONCEW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic                     abort,
    output logic [NCORES-1:0]        core_start,
    output logic [NONCEW-1:0]        core_base,
    output logic                     core_kill,
    input  logic [NCORES-1:0]        core_done,
    input  logic [NCORES-1:0]        hit_valid,
    input  logic [NCORES*NONCEW-1:0] hit_nonce,
    output logic [NCORES-1:0]        hit_ready,
    output logic                     nb_wr_en,
    output logic [NONCEW-1:0]        nb_wr_data,
    input  logic                     nb_full,
    output logic                     busy,
    output logic                     exhausted
);

    localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [NONCEW:0] CHUNK = {{NONCEW{1'b0}}, 1'b1} << COUNTBITS;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t            state;
    logic [NCORES-1:0] core_busy;
    logic [NONCEW-1:0] next_base;
    logic [PW-1:0]     rr_ptr;

    logic [NCORES-1:0] start_vec;
    logic              start_ok;
    logic [NCORES-1:0] busy_after_done;
    logic [NONCEW-1:0] issue_base;
    logic [NONCEW-1:0] base_sum;
    logic              base_carry;
    logic              accept;
    logic              issue;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     rr_next;
    logic [NONCEW-1:0] win_nonce;
    logic              grant;

    assign blk_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Pick the lowest-index idle core from the busy vector held before the edge.
    always_comb begin
        start_vec = '0;
        start_ok  = 1'b0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (!core_busy[i] && !start_ok) begin
                start_vec[i] = 1'b1;
                start_ok     = 1'b1;
            end
        end
    end

    // Chunk base for this cycle; the accepting cycle issues chunk 0 directly so
    // the first start lands on the edge that accepts the block.
    always_comb begin
        busy_after_done          = core_busy & ~core_done;
        issue_base               = (state == IDLE) ? '0 : next_base;
        {base_carry, base_sum}   = {1'b0, issue_base} + CHUNK;
        accept                   = (state == IDLE) && blk_valid && !abort;
        issue                    = !abort && start_ok && (accept || (state == DISPATCH));
    end

    // Round-robin search over hit_valid starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            cand = PW'((32'(rr_ptr) + k) % NCORES);
            if (!win_found && hit_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_nonce = hit_nonce[32'(win_idx) * NONCEW +: NONCEW];
        rr_next   = (win_idx == PW'(NCORES - 1)) ? '0 : win_idx + PW'(1);
        grant     = win_found && !nb_full && !abort;
        hit_ready = '0;
        if (grant) begin
            hit_ready[win_idx] = 1'b1;
        end
    end

    // Control FSM, dispatch bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            core_busy  <= '0;
            next_base  <= '0;
            rr_ptr     <= '0;
            core_start <= '0;
            core_base  <= '0;
            core_kill  <= 1'b0;
            nb_wr_en   <= 1'b0;
            nb_wr_data <= '0;
            exhausted  <= 1'b0;
        end else begin
            core_start <= '0;
            core_kill  <= 1'b0;
            exhausted  <= 1'b0;
            nb_wr_en   <= grant;
            if (grant) begin
                nb_wr_data <= win_nonce;
                rr_ptr     <= rr_next;
            end

            if (abort) begin
                core_kill <= 1'b1;
                core_busy <= '0;
                state     <= IDLE;
            end else begin
                if (issue) begin
                    core_start <= start_vec;
                    core_base  <= issue_base;
                    next_base  <= base_sum;
                    core_busy  <= busy_after_done | start_vec;
                end else begin
                    core_busy  <= busy_after_done;
                end

                case (state)
                    IDLE: begin
                        if (blk_valid) begin
                            state <= DISPATCH;
                            if (!start_ok) begin
                                next_base <= '0;
                            end
                        end
                    end
                    DISPATCH: begin
                    end
                    DRAIN: begin
                        if (busy_after_done == '0) begin
                            exhausted <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (issue && base_carry) begin
                    state <= DRAIN;
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Directed bench for nonce_dispatch_ctrl: a 4-chunk instance for dispatch,
// arbitration, abort and reset, and an 8-chunk instance for exhaustion.
module tb_nonce_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 4-chunk instance (NONCEW=10)
    logic        blk_valid = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  core_done = '0;
    logic [3:0]  hit_valid = '0;
    logic [39:0] hit_nonce = '0;
    logic        nb_full = 1'b0;
    logic        blk_ready, core_kill, nb_wr_en, busy, exhausted;
    logic [3:0]  core_start, hit_ready;
    logic [9:0]  core_base, nb_wr_data;

    // 8-chunk instance (NONCEW=11)
    logic        blk_valid11 = 1'b0;
    logic        abort11 = 1'b0;
    logic [3:0]  core_done11 = '0;
    logic [3:0]  hit_valid11 = '0;
    logic [43:0] hit_nonce11 = '0;
    logic        nb_full11 = 1'b0;
    logic        blk_ready11, core_kill11, nb_wr_en11, busy11, exhausted11;
    logic [3:0]  core_start11, hit_ready11;
    logic [10:0] core_base11, nb_wr_data11;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nonce_dispatch_ctrl #(.NCORES(4), .COUNTBITS(8), .NONCEW(10)) u_dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .abort(abort), .core_start(core_start), .core_base(core_base),
        .core_kill(core_kill), .core_done(core_done), .hit_valid(hit_valid),
        .hit_nonce(hit_nonce), .hit_ready(hit_ready), .nb_wr_en(nb_wr_en),
        .nb_wr_data(nb_wr_data), .nb_full(nb_full), .busy(busy),
        .exhausted(exhausted)
    );

    nonce_dispatch_ctrl #(.NCORES(4), .COUNTBITS(8), .NONCEW(11)) u_dut11 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid11), .blk_ready(blk_ready11),
        .abort(abort11), .core_start(core_start11), .core_base(core_base11),
        .core_kill(core_kill11), .core_done(core_done11), .hit_valid(hit_valid11),
        .hit_nonce(hit_nonce11), .hit_ready(hit_ready11), .nb_wr_en(nb_wr_en11),
        .nb_wr_data(nb_wr_data11), .nb_full(nb_full11), .busy(busy11),
        .exhausted(exhausted11)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (blk_ready !== 1'b1) begin fails++; $display("FAIL reset_blk_ready: got %b want 1", blk_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if ({core_start, core_kill, nb_wr_en, exhausted, hit_ready} !== 11'b0) begin fails++; $display("FAIL reset_pulses: got %b want 0", {core_start, core_kill, nb_wr_en, exhausted, hit_ready}); end
        tests++; if ({core_base, nb_wr_data} !== 20'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {core_base, nb_wr_data}); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_dispatch();
        logic [3:0] exp_start [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [9:0] exp_base  [4] = '{10'h000, 10'h100, 10'h200, 10'h300};
        blk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            blk_valid = 1'b0;
            tests++; if (core_start !== exp_start[i] || core_base !== exp_base[i]) begin fails++; $display("FAIL dispatch_%0d: got start=%b base=%h want start=%b base=%h", i, core_start, core_base, exp_start[i], exp_base[i]); end
        end
        step();
        tests++; if (core_start !== 4'b0 || busy !== 1'b1 || blk_ready !== 1'b0) begin fails++; $display("FAIL dispatch_after: got start=%b busy=%b rdy=%b want 0000 1 0", core_start, busy, blk_ready); end
        // freeing core 0 must not trigger a start once the space is fully issued
        core_done = 4'b0001;
        step();
        core_done = 4'b0000;
        tests++; if (core_start !== 4'b0) begin fails++; $display("FAIL drain_nostart_a: got %b want 0000", core_start); end
        step();
        tests++; if (core_start !== 4'b0 || exhausted !== 1'b0) begin fails++; $display("FAIL drain_nostart_b: got start=%b exh=%b want 0000 0", core_start, exhausted); end
    endtask

    task automatic test_async_reset();
        hit_nonce = {10'h000, 10'h000, 10'h2A5, 10'h000};
        hit_valid = 4'b0010;
        #1;
        tests++; if (hit_ready !== 4'b0010) begin fails++; $display("FAIL areset_hit_ready: got %b want 0010", hit_ready); end
        step();
        hit_valid = 4'b0000;
        tests++; if (nb_wr_en !== 1'b1 || nb_wr_data !== 10'h2A5) begin fails++; $display("FAIL areset_pre_write: got en=%b data=%h want 1 2a5", nb_wr_en, nb_wr_data); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (blk_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL areset_state: got rdy=%b busy=%b want 1 0", blk_ready, busy); end
        tests++; if ({core_start, core_kill, nb_wr_en, exhausted} !== 7'b0 || {core_base, nb_wr_data} !== 20'h0) begin fails++; $display("FAIL areset_outputs: got ctl=%b data=%h want 0 0", {core_start, core_kill, nb_wr_en, exhausted}, {core_base, nb_wr_data}); end
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_hit_arb();
        logic [9:0] exp_nonce [4] = '{10'h011, 10'h022, 10'h033, 10'h044};
        logic [3:0] exp_rdy;
        hit_nonce = {10'h044, 10'h033, 10'h022, 10'h011};
        hit_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = 4'b0001 << i;
            #1;
            tests++; if (hit_ready !== exp_rdy) begin fails++; $display("FAIL hit_ready_%0d: got %b want %b", i, hit_ready, exp_rdy); end
            step();
            hit_valid[i] = 1'b0;
            tests++; if (nb_wr_en !== 1'b1 || nb_wr_data !== exp_nonce[i]) begin fails++; $display("FAIL hit_write_%0d: got en=%b data=%h want 1 %h", i, nb_wr_en, nb_wr_data, exp_nonce[i]); end
        end
        step();
        tests++; if (nb_wr_en !== 1'b0) begin fails++; $display("FAIL hit_idle: got en=%b want 0", nb_wr_en); end
    endtask

    task automatic test_backpressure();
        hit_nonce = {10'h000, 10'h155, 10'h000, 10'h000};
        hit_valid = 4'b0100;
        nb_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (hit_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0000", i, hit_ready); end
            step();
            tests++; if (nb_wr_en !== 1'b0) begin fails++; $display("FAIL bp_wr_en_%0d: got %b want 0", i, nb_wr_en); end
        end
        nb_full = 1'b0;
        #1;
        tests++; if (hit_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready: got %b want 0100", hit_ready); end
        step();
        hit_valid = 4'b0000;
        tests++; if (nb_wr_en !== 1'b1 || nb_wr_data !== 10'h155) begin fails++; $display("FAIL bp_release_write: got en=%b data=%h want 1 155", nb_wr_en, nb_wr_data); end
        step();
        tests++; if (nb_wr_en !== 1'b0) begin fails++; $display("FAIL bp_single_write: got en=%b want 0", nb_wr_en); end
    endtask

    task automatic test_abort();
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        step();
        tests++; if (core_start !== 4'b0010) begin fails++; $display("FAIL abort_setup: got %b want 0010", core_start); end
        abort = 1'b1;
        blk_valid = 1'b1;
        hit_nonce = {10'h000, 10'h000, 10'h000, 10'h3C3};
        hit_valid = 4'b0001;
        #1;
        tests++; if (hit_ready !== 4'b0000) begin fails++; $display("FAIL abort_hit_ready: got %b want 0000", hit_ready); end
        step();
        abort = 1'b0;
        blk_valid = 1'b0;
        hit_valid = 4'b0000;
        tests++; if (core_kill !== 1'b1 || core_start !== 4'b0) begin fails++; $display("FAIL abort_kill: got kill=%b start=%b want 1 0000", core_kill, core_start); end
        tests++; if (blk_ready !== 1'b1 || busy !== 1'b0 || exhausted !== 1'b0 || nb_wr_en !== 1'b0) begin fails++; $display("FAIL abort_state: got rdy=%b busy=%b exh=%b wr=%b want 1 0 0 0", blk_ready, busy, exhausted, nb_wr_en); end
        step();
        tests++; if (core_kill !== 1'b0 || exhausted !== 1'b0) begin fails++; $display("FAIL abort_kill_len: got kill=%b exh=%b want 0 0", core_kill, exhausted); end
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        tests++; if (core_start !== 4'b0001 || core_base !== 10'h000) begin fails++; $display("FAIL abort_restart: got start=%b base=%h want 0001 000", core_start, core_base); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_exhaustion();
        logic [3:0]  exp_start [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [10:0] exp_base  [4] = '{11'h000, 11'h100, 11'h200, 11'h300};
        logic [3:0]  refill    [3] = '{4'b0001, 4'b0010, 4'b1000};
        logic [10:0] refill_b  [3] = '{11'h500, 11'h600, 11'h700};
        blk_valid11 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            blk_valid11 = 1'b0;
            tests++; if (core_start11 !== exp_start[i] || core_base11 !== exp_base[i]) begin fails++; $display("FAIL exh_start_%0d: got start=%b base=%h want start=%b base=%h", i, core_start11, core_base11, exp_start[i], exp_base[i]); end
        end
        core_done11 = 4'b0100;
        step();
        core_done11 = 4'b0000;
        tests++; if (core_start11 !== 4'b0000) begin fails++; $display("FAIL exh_done_edge: got %b want 0000", core_start11); end
        step();
        tests++; if (core_start11 !== 4'b0100 || core_base11 !== 11'h400) begin fails++; $display("FAIL exh_refill_c2: got start=%b base=%h want 0100 400", core_start11, core_base11); end
        for (int i = 0; i < 3; i++) begin
            core_done11 = refill[i];
            step();
            core_done11 = 4'b0000;
            step();
            tests++; if (core_start11 !== refill[i] || core_base11 !== refill_b[i]) begin fails++; $display("FAIL exh_refill_%0d: got start=%b base=%h want start=%b base=%h", i, core_start11, core_base11, refill[i], refill_b[i]); end
        end
        core_done11 = 4'b0011;
        step();
        core_done11 = 4'b0000;
        tests++; if (exhausted11 !== 1'b0 || blk_ready11 !== 1'b0) begin fails++; $display("FAIL exh_early: got exh=%b rdy=%b want 0 0", exhausted11, blk_ready11); end
        step();
        tests++; if (core_start11 !== 4'b0000 || exhausted11 !== 1'b0) begin fails++; $display("FAIL exh_drain_nostart: got start=%b exh=%b want 0000 0", core_start11, exhausted11); end
        core_done11 = 4'b1100;
        step();
        core_done11 = 4'b0000;
        tests++; if (exhausted11 !== 1'b1 || blk_ready11 !== 1'b1) begin fails++; $display("FAIL exh_pulse: got exh=%b rdy=%b want 1 1", exhausted11, blk_ready11); end
        step();
        tests++; if (exhausted11 !== 1'b0 || blk_ready11 !== 1'b1) begin fails++; $display("FAIL exh_once: got exh=%b rdy=%b want 0 1", exhausted11, blk_ready11); end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_async_reset();
        test_hit_arb();
        test_backpressure();
        test_abort();
        test_exhaustion();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
